// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer: saves Status/Cause/EPC and redirects the PC, or restores on ERET.
// Optional exception masking via `define CP0_EXC_MASK_EN.
module cp0_exc_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
  parameter int unsigned STATUS_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] epc_in,
  input  logic        eret_req,
  output logic        cp0_r,
  output logic [4:0]  cp0_raddr,
  input  logic [31:0] cp0_rdata,
  output logic        cp0_w,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exc_ignored
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic [3:0] {
    S_IDLE,
    S_E_RD_ST,
    S_E_WR_ST,
    S_E_WR_CA,
    S_E_WR_EPC,
    S_E_DONE,
    S_R_RD_ST,
    S_R_WR_ST,
    S_R_RD_EPC,
    S_R_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_in_q, epc_in_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;

  logic        cp0_r_q, cp0_r_d;
  logic [4:0]  cp0_raddr_q, cp0_raddr_d;
  logic        cp0_w_q, cp0_w_d;
  logic [4:0]  cp0_waddr_q, cp0_waddr_d;
  logic [31:0] cp0_wdata_q, cp0_wdata_d;
  logic        busy_q, busy_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

`ifdef CP0_EXC_MASK_EN
  logic exc_ignored_q, exc_ignored_d;

  function automatic logic exc_taken(input logic [31:0] st, input logic [4:0] code);
    logic taken;
    case (code)
      5'd8:    taken = st[0] & st[8];
      5'd9:    taken = st[0] & st[9];
      5'd13:   taken = st[0] & st[10];
      default: taken = 1'b1;
    endcase
    return taken;
  endfunction
`endif

  // Next state and captures
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    epc_in_d = epc_in_q;
    status_d = status_q;
    epc_d    = epc_q;
    case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          code_d   = exc_code;
          epc_in_d = epc_in;
          state_d  = S_E_RD_ST;
        end else if (eret_req) begin
          state_d = S_R_RD_ST;
        end
      end
      S_E_RD_ST: begin
        status_d = cp0_rdata;
        state_d  = S_E_WR_ST;
`ifdef CP0_EXC_MASK_EN
        if (!exc_taken(cp0_rdata, code_q)) state_d = S_IDLE;
`endif
      end
      S_E_WR_ST:  state_d = S_E_WR_CA;
      S_E_WR_CA:  state_d = S_E_WR_EPC;
      S_E_WR_EPC: state_d = S_E_DONE;
      S_E_DONE:   state_d = S_IDLE;
      S_R_RD_ST: begin
        status_d = cp0_rdata;
        state_d  = S_R_WR_ST;
      end
      S_R_WR_ST:  state_d = S_R_RD_EPC;
      S_R_RD_EPC: begin
        epc_d   = cp0_rdata;
        state_d = S_R_DONE;
      end
      S_R_DONE:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so the CP0
  // controls hold steady for the whole cycle the state occupies.
  always_comb begin
    cp0_r_d          = 1'b0;
    cp0_raddr_d      = '0;
    cp0_w_d          = 1'b0;
    cp0_waddr_d      = '0;
    cp0_wdata_d      = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    busy_d           = (state_d != S_IDLE);
    case (state_d)
      S_E_RD_ST, S_R_RD_ST: begin
        cp0_r_d     = 1'b1;
        cp0_raddr_d = ADDR_STATUS;
      end
      S_E_WR_ST: begin
        cp0_w_d     = 1'b1;
        cp0_waddr_d = ADDR_STATUS;
        cp0_wdata_d = status_d << STATUS_SHIFT;
      end
      S_E_WR_CA: begin
        cp0_w_d     = 1'b1;
        cp0_waddr_d = ADDR_CAUSE;
        cp0_wdata_d = {25'b0, code_d, 2'b0};
      end
      S_E_WR_EPC: begin
        cp0_w_d     = 1'b1;
        cp0_waddr_d = ADDR_EPC;
        cp0_wdata_d = epc_in_d;
      end
      S_E_DONE: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = HANDLER_ADDR;
      end
      S_R_WR_ST: begin
        cp0_w_d     = 1'b1;
        cp0_waddr_d = ADDR_STATUS;
        cp0_wdata_d = status_d >> STATUS_SHIFT;
      end
      S_R_RD_EPC: begin
        cp0_r_d     = 1'b1;
        cp0_raddr_d = ADDR_EPC;
      end
      S_R_DONE: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = epc_d;
      end
      default: ;
    endcase
  end

`ifdef CP0_EXC_MASK_EN
  always_comb begin
    exc_ignored_d = (state_q == S_E_RD_ST) && (state_d == S_IDLE);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      code_q           <= '0;
      epc_in_q         <= '0;
      status_q         <= '0;
      epc_q            <= '0;
      cp0_r_q          <= 1'b0;
      cp0_raddr_q      <= '0;
      cp0_w_q          <= 1'b0;
      cp0_waddr_q      <= '0;
      cp0_wdata_q      <= '0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
`ifdef CP0_EXC_MASK_EN
      exc_ignored_q    <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      code_q           <= code_d;
      epc_in_q         <= epc_in_d;
      status_q         <= status_d;
      epc_q            <= epc_d;
      cp0_r_q          <= cp0_r_d;
      cp0_raddr_q      <= cp0_raddr_d;
      cp0_w_q          <= cp0_w_d;
      cp0_waddr_q      <= cp0_waddr_d;
      cp0_wdata_q      <= cp0_wdata_d;
      busy_q           <= busy_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
`ifdef CP0_EXC_MASK_EN
      exc_ignored_q    <= exc_ignored_d;
`endif
    end
  end

  // Gating the strobes with rst stops the CP0 negedge write in the very
  // cycle reset is raised, before the synchronous reset clears the flops.
  assign cp0_r          = cp0_r_q & ~rst;
  assign cp0_w          = cp0_w_q & ~rst;
  assign cp0_raddr      = cp0_raddr_q;
  assign cp0_waddr      = cp0_waddr_q;
  assign cp0_wdata      = cp0_wdata_q;
  assign busy           = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
`ifdef CP0_EXC_MASK_EN
  assign exc_ignored    = exc_ignored_q;
`else
  assign exc_ignored    = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Self-checking bench for cp0_exc_seq: CP0 register model, vector table, corner sequences, random traffic.
module tb_cp0_exc_seq;

  localparam logic [31:0] HANDLER = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req, eret_req;
  logic [4:0]  exc_code;
  logic [31:0] epc_in;
  logic        cp0_r, cp0_w;
  logic [4:0]  cp0_raddr, cp0_waddr;
  logic [31:0] cp0_rdata, cp0_wdata;
  logic        busy, redirect_valid, exc_ignored;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  cp0_exc_seq #(.HANDLER_ADDR(HANDLER), .STATUS_SHIFT(5)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_code(exc_code), .epc_in(epc_in),
    .eret_req(eret_req), .cp0_r(cp0_r), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .cp0_w(cp0_w), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_ignored(exc_ignored)
  );

  logic [31:0] cp0_regs [32];
  assign cp0_rdata = cp0_regs[cp0_raddr];

  typedef struct {
    int          k;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         obs_w[$];
  wr_t         exp_w[$];
  int          n_rv, obs_rv_k, n_ign, obs_ign_k, overlap;
  logic [31:0] obs_pc;
  logic [7:0]  obs_busy;
  int          exp_rv_k, exp_ign_k;
  logic [31:0] exp_pc;
  logic [7:0]  exp_busy;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_w.delete();
    n_rv = 0; obs_rv_k = 0; n_ign = 0; obs_ign_k = 0; overlap = 0;
    obs_pc = '0; obs_busy = '0;
  endtask

  // CP0 commits on the falling edge; outputs are observed there too
  task automatic sample(input int k);
    @(negedge clk);
    if (cp0_w && cp0_r) overlap++;
    if (cp0_w) begin
      obs_w.push_back('{k, cp0_waddr, cp0_wdata});
      cp0_regs[cp0_waddr] = cp0_wdata;
    end
    if (redirect_valid) begin
      n_rv++; obs_rv_k = k; obs_pc = redirect_pc;
    end
    if (exc_ignored) begin
      n_ign++; obs_ign_k = k;
    end
    if (k >= 1 && k <= 8) obs_busy[k-1] = busy;
  endtask

  task automatic start(input bit ex, input bit er, input logic [4:0] code, input logic [31:0] epci);
    clear_obs();
    @(posedge clk); #1;
    exc_req = ex; eret_req = er; exc_code = code; epc_in = epci;
    @(posedge clk); #1;
    exc_req = 1'b0; eret_req = 1'b0;
  endtask

  task automatic run(input bit ex, input bit er, input logic [4:0] code, input logic [31:0] epci);
    start(ex, er, code, epci);
    for (int k = 1; k <= 8; k++) sample(k);
  endtask

  // Reference: what CP0 should see for one request, from the architectural rules
  task automatic model(input bit ex, input bit er, input logic [4:0] code, input logic [31:0] epci,
                       input logic [31:0] st, input logic [31:0] epcr);
    bit taken;
    int done;
    exp_w.delete();
    exp_rv_k = 0; exp_ign_k = 0; exp_pc = '0; done = 0;
    if (ex) begin
      taken = 1'b1;
`ifdef CP0_EXC_MASK_EN
      if (code == 5'd8)  taken = st[0] && st[8];
      if (code == 5'd9)  taken = st[0] && st[9];
      if (code == 5'd13) taken = st[0] && st[10];
`endif
      if (taken) begin
        exp_w.push_back('{2, 5'd12, st * 32'd32});
        exp_w.push_back('{3, 5'd13, 32'(code) * 32'd4});
        exp_w.push_back('{4, 5'd14, epci});
        exp_rv_k = 5; exp_pc = HANDLER; done = 5;
      end else begin
        exp_ign_k = 2; done = 1;
      end
    end else if (er) begin
      exp_w.push_back('{2, 5'd12, st / 32'd32});
      exp_rv_k = 4; exp_pc = epcr; done = 4;
    end
    exp_busy = 8'((1 << done) - 1);
  endtask

  task automatic check_txn(input string tag);
    chk({tag, ".nwr"}, 64'(obs_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      chk($sformatf("%s.wr%0d", tag, i), {24'(obs_w[i].k), 3'b0, obs_w[i].addr, obs_w[i].data},
          {24'(exp_w[i].k), 3'b0, exp_w[i].addr, exp_w[i].data});
    chk({tag, ".nrv"}, 64'(n_rv), (exp_rv_k != 0) ? 64'd1 : 64'd0);
    if (exp_rv_k != 0) chk({tag, ".rv"}, {obs_rv_k, obs_pc}, {exp_rv_k, exp_pc});
    chk({tag, ".ign"}, {n_ign, obs_ign_k}, {(exp_ign_k != 0) ? 1 : 0, exp_ign_k});
    chk({tag, ".busy"}, 64'(obs_busy), 64'(exp_busy));
    chk({tag, ".rw_overlap"}, 64'(overlap), 64'd0);
  endtask

  typedef struct {
    bit          ex;
    bit          er;
    logic [31:0] st;
    logic [31:0] epcr;
    logic [4:0]  code;
    logic [31:0] epci;
    logic [31:0] exp_st;
    logic [31:0] exp_ca;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    rst = 1'b1; exc_req = 1'b0; eret_req = 1'b0; exc_code = '0; epc_in = '0;
    for (int i = 0; i < 32; i++) cp0_regs[i] = '0;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0701, 32'h0,         5'd8,  32'h0040_0100,
               32'h0000_E020, 32'h0000_0020, 32'h0040_0004, 5};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_E020, 32'h0040_0100, 5'd0,  32'h0,
               32'h0000_0701, 32'h0,         32'h0040_0100, 4};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0701, 32'h0,         5'd13, 32'h0040_0200,
               32'h0000_E020, 32'h0000_0034, 32'h0040_0004, 5};
    tbl[3] = '{1'b1, 1'b0, 32'h8000_0003, 32'h0,         5'd31, 32'hDEAD_BEE0,
               32'h0000_0060, 32'h0000_007C, 32'h0040_0004, 5};

    // Reset held for two cycles
    clear_obs();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      sample(0);
      chk("reset.outs", {cp0_r, cp0_w, busy, redirect_valid, exc_ignored, cp0_raddr, cp0_waddr},
          '0);
      chk("reset.wdata_pc", {cp0_wdata, redirect_pc}, '0);
    end
    chk("reset.nwr", 64'(obs_w.size()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      cp0_regs[12] = tbl[v].st;
      cp0_regs[13] = 32'h5555_5555;
      cp0_regs[14] = tbl[v].ex ? 32'h0 : tbl[v].epcr;
      run(tbl[v].ex, tbl[v].er, tbl[v].code, tbl[v].epci);
      chk($sformatf("vec%0d.status", v), 64'(cp0_regs[12]), 64'(tbl[v].exp_st));
      chk($sformatf("vec%0d.cause", v), 64'(cp0_regs[13]),
          tbl[v].ex ? 64'(tbl[v].exp_ca) : 64'h5555_5555);
      chk($sformatf("vec%0d.epc", v), 64'(cp0_regs[14]),
          tbl[v].ex ? 64'(tbl[v].epci) : 64'(tbl[v].epcr));
      chk($sformatf("vec%0d.redirect", v), {n_rv, obs_rv_k, obs_pc},
          {1, tbl[v].exp_lat, tbl[v].exp_pc});
      chk($sformatf("vec%0d.busy", v), 64'(obs_busy), 64'((1 << tbl[v].exp_lat) - 1));
    end

    // Reset raised in the Cause-write cycle
    cp0_regs[12] = 32'h0000_0701;
    cp0_regs[13] = 32'h1111_1111;
    cp0_regs[14] = 32'h2222_2222;
    start(1'b1, 1'b0, 5'd9, 32'h0040_0300);
    sample(1);
    sample(2);
    @(posedge clk); #1;
    rst = 1'b1;
    sample(3);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 4; k <= 8; k++) sample(k);
    chk("rstmid.status", 64'(cp0_regs[12]), 64'h0000_E020);
    chk("rstmid.cause", 64'(cp0_regs[13]), 64'h1111_1111);
    chk("rstmid.epc", 64'(cp0_regs[14]), 64'h2222_2222);
    chk("rstmid.nrv", 64'(n_rv), 64'd0);
    chk("rstmid.busy_after", 64'(obs_busy[7:3]), 64'd0);
    chk("rstmid.nwr", 64'(obs_w.size()), 64'd1);

`ifdef CP0_EXC_MASK_EN
    cp0_regs[12] = 32'h0000_0001;
    run(1'b1, 1'b0, 5'd9, 32'h0040_0400);
    chk("mask.ign", {n_ign, obs_ign_k}, {1, 2});
    chk("mask.nwr", 64'(obs_w.size()), 64'd0);
    chk("mask.busy", 64'(obs_busy), 64'h1);
    chk("mask.nrv", 64'(n_rv), 64'd0);
    cp0_regs[12] = 32'h0000_0201;
    run(1'b1, 1'b0, 5'd9, 32'h0040_0400);
    chk("unmask.nign", 64'(n_ign), 64'd0);
    chk("unmask.redirect", {n_rv, obs_rv_k}, {1, 5});
    chk("unmask.epc", 64'(cp0_regs[14]), 64'h0040_0400);
`endif

    // Randomised traffic against the reference
    for (int t = 0; t < 40; t++) begin
      logic [31:0] st, epcr, epci;
      logic [4:0]  code;
      int          kind;
      bit          ex, er;
      st   = $urandom;
      epcr = $urandom;
      epci = $urandom;
      case ($urandom_range(0, 3))
        0:       code = 5'd8;
        1:       code = 5'd9;
        2:       code = 5'd13;
        default: code = 5'($urandom);
      endcase
      kind = $urandom_range(0, 3);
      ex = (kind == 0) || (kind == 2);
      er = (kind == 1) || (kind == 2);
      cp0_regs[12] = st;
      cp0_regs[14] = epcr;
      model(ex, er, code, epci, st, epcr);
      run(ex, er, code, epci);
      check_txn($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_seq.md
Name: cp0_exc_seq

Overview:
- Multi-cycle exception/ERET sequencer that drives the CP0 register file through its read and write ports.
- On a syscall/break/teq request it saves Status, Cause and EPC, then redirects the PC to the handler.
- On ERET it restores Status, reads EPC and redirects the PC back.
- Sits between the multi-cycle control unit and CP0; it is the only master of the CP0 ports while busy.

Parameters:
- HANDLER_ADDR, 32'h0040_0004, PC value issued on exception entry.
- STATUS_SHIFT, 5, bit shift applied to Status on entry (left) and on ERET (right).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- exc_req  input  1  exception request; sampled only in IDLE.
- exc_code  input  5  ExcCode: 8 syscall, 9 break, 13 teq.
- epc_in  input  32  address of the excepting instruction.
- eret_req  input  1  ERET request; sampled only in IDLE.
- cp0_r  output  1  CP0 read enable.
- cp0_raddr  output  5  CP0 read address.
- cp0_rdata  input  32  CP0 read data; combinational, same cycle.
- cp0_w  output  1  CP0 write enable; CP0 commits on negedge within the same cycle.
- cp0_waddr  output  5  CP0 write address.
- cp0_wdata  output  32  CP0 write data.
- busy  output  1  high in every state except IDLE.
- redirect_valid  output  1  one-cycle pulse; PC must load redirect_pc.
- redirect_pc  output  32  target PC; valid only while redirect_valid is high.
- exc_ignored  output  1  one-cycle pulse; request dropped (optional feature only).

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs 0, including cp0_r, cp0_w, redirect_valid, busy and exc_ignored.
  - Internal captures (code_q, epc_in_q, status_q, epc_q) are cleared.
- CP0 addresses: Status 12, Cause 13, EPC 14.
- Register outputs so each state's CP0 controls are stable for that whole cycle. The CP0 negedge write then lands mid-cycle.
- IDLE:
  - exc_req=1: latch exc_code into code_q and epc_in into epc_in_q, go to E_RD_ST.
  - Otherwise eret_req=1: go to R_RD_ST.
  - Both high at once: the exception wins and ERET is discarded (not queued).
- Exception path (one cycle per state):
  - E_RD_ST: cp0_r=1, raddr=12; capture status_q <= cp0_rdata at the end of the cycle.
  - E_WR_ST: cp0_w=1, waddr=12, wdata = status_q << STATUS_SHIFT (zero fill, 32-bit truncation).
  - E_WR_CA: cp0_w=1, waddr=13, wdata = {25'b0, code_q, 2'b0}.
  - E_WR_EPC: cp0_w=1, waddr=14, wdata = epc_in_q.
  - E_DONE: redirect_valid=1, redirect_pc=HANDLER_ADDR; return to IDLE.
- ERET path:
  - R_RD_ST: cp0_r=1, raddr=12; capture status_q.
  - R_WR_ST: cp0_w=1, waddr=12, wdata = status_q >> STATUS_SHIFT (logical).
  - R_RD_EPC: cp0_r=1, raddr=14; capture epc_q.
  - R_DONE: redirect_valid=1, redirect_pc=epc_q; return to IDLE.
- Latency, counting from the posedge that samples the request in IDLE:
  - Exception: redirect_valid is high in the 5th following cycle.
  - ERET: redirect_valid is high in the 4th following cycle.
- Exactly one write per write state. cp0_w and cp0_r are never high in the same cycle.
- While busy, exc_req and eret_req are ignored and not queued. The control unit must hold the request until busy deasserts.
- A new request may be sampled in the cycle after E_DONE/R_DONE; there is no back-to-back bubble beyond that.
- Reset mid-sequence: return to IDLE next posedge; no further CP0 writes. Writes already committed stay in CP0.
- Unknown exc_code is still processed; code_q is written verbatim into Cause.

Optional Feature:
- Macro: CP0_EXC_MASK_EN.
- Enabled: E_RD_ST additionally checks the captured Status.
  - Request is taken only if Status[0]=1 (IE) and the cause mask bit is 1: bit 8 syscall, bit 9 break, bit 10 teq. Any other code is always taken.
  - If masked: no writes, exc_ignored=1 for one cycle, busy low, return to IDLE. Latency from request sample to the exc_ignored pulse is 2 cycles.
- Disabled: every exception is taken; exc_ignored is tied 0.

Test Plan:
- Reset, then hold rst=1 for 2 cycles -> all outputs 0, busy=0; CP0 model sees no write.
- Status=32'h0000_0701, exc_req with code 8, epc_in=32'h0040_0100 -> writes in order:
  - Status <= 32'h0000_E020
  - Cause <= 32'h0000_0020
  - EPC <= 32'h0040_0100
  - then redirect_valid pulse with redirect_pc=32'h0040_0004 in cycle 5.
- Following ERET, Status=32'h0000_E020, EPC=32'h0040_0100 -> Status <= 32'h0000_0701; redirect_pc=32'h0040_0104 minus 4 (i.e. 32'h0040_0100) in cycle 4; busy low after.
- exc_req and eret_req high together in IDLE (code 13) -> exception path only; Cause=32'h0000_0034; no ERET afterwards.
- rst asserted during E_WR_CA -> Status already updated; Cause and EPC unchanged; redirect_valid never pulses; state IDLE.
- CP0_EXC_MASK_EN, Status=32'h0000_0001, code 9 -> exc_ignored pulse at cycle 2; zero CP0 writes. Status=32'h0000_0201, code 9 -> taken.
